// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle control FSM for an RV32 subset (R/I-type ALU, LW, SW).
// Sequences fetch/decode/execute/memory/writeback and flags illegal ops and memory timeouts.
module rv_multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             clear,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    output logic             imem_req,
    input  logic             imem_ready,
    output logic             dmem_req,
    output logic             dmem_we,
    input  logic             dmem_ready,
    output logic             ir_load,
    output logic             alu_en,
    output logic             alu_src_imm,
    output logic             reg_we,
    output logic             wb_sel_mem,
    output logic             pc_en,
    output logic             retire,
    output logic             busy,
    output logic             illegal,
    output logic             timeout,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retire_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        C_RTYPE = 2'd0,
        C_ITYPE = 2'd1,
        C_LOAD  = 2'd2,
        C_STORE = 2'd3
    } iclass_t;

    localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_t            state_q, state_d;
    iclass_t           cls_q, dec_cls;
    logic              dec_ok;
    logic [WAIT_W-1:0] wait_cnt;
    logic              wait_hit;
    logic              set_illegal, set_timeout, clr_flags;
    logic              illegal_q, timeout_q;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        dec_cls = C_RTYPE;
        dec_ok  = 1'b0;
        case (opcode)
            7'b0110011: begin
                dec_cls = C_RTYPE;
                dec_ok  = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
            end
            7'b0010011: begin
                dec_cls = C_ITYPE;
                dec_ok  = 1'b1;
            end
            7'b0000011: begin
                dec_cls = C_LOAD;
                dec_ok  = (funct3 == 3'b010);
            end
            7'b0100011: begin
                dec_cls = C_STORE;
                dec_ok  = (funct3 == 3'b010);
            end
            default: ;
        endcase
    end

    // The limit cycle is the TIMEOUT_CYCLES-th waiting cycle; ready in that cycle still wins.
    assign wait_hit = (wait_cnt == WAIT_LAST);

    always_comb begin
        state_d     = state_q;
        imem_req    = 1'b0;
        ir_load     = 1'b0;
        dmem_req    = 1'b0;
        dmem_we     = 1'b0;
        alu_en      = 1'b0;
        alu_src_imm = 1'b0;
        reg_we      = 1'b0;
        wb_sel_mem  = 1'b0;
        pc_en       = 1'b0;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        clr_flags   = 1'b0;
        case (state_q)
            S_IDLE: if (run) state_d = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_hit) begin
                    state_d     = S_HALT;
                    set_timeout = 1'b1;
                end
            end
            S_DECODE: begin
                if (dec_ok) begin
                    state_d = S_EXEC;
                end else begin
                    state_d     = S_HALT;
                    set_illegal = 1'b1;
                end
            end
            S_EXEC: begin
                alu_en      = 1'b1;
                alu_src_imm = (cls_q != C_RTYPE);
                state_d     = (cls_q == C_LOAD || cls_q == C_STORE) ? S_MEM : S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (cls_q == C_STORE);
                if (dmem_ready) begin
                    state_d = S_WB;
                end else if (wait_hit) begin
                    state_d     = S_HALT;
                    set_timeout = 1'b1;
                end
            end
            S_WB: begin
                pc_en      = 1'b1;
                retire     = 1'b1;
                reg_we     = (cls_q != C_STORE);
                wb_sel_mem = (cls_q == C_LOAD);
                state_d    = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                if (clear) begin
                    state_d   = S_IDLE;
                    clr_flags = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cls_q      <= C_RTYPE;
            wait_cnt   <= '0;
            illegal_q  <= 1'b0;
            timeout_q  <= 1'b0;
            retire_cnt <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) cls_q <= dec_cls;
            // Zero outside FETCH/MEM, so the count always starts at 0 on entry to either.
            if ((state_q == S_FETCH && !imem_ready) || (state_q == S_MEM && !dmem_ready))
                wait_cnt <= wait_cnt + 1'b1;
            else
                wait_cnt <= '0;
            if (set_illegal)    illegal_q <= 1'b1;
            else if (clr_flags) illegal_q <= 1'b0;
            if (set_timeout)    timeout_q <= 1'b1;
            else if (clr_flags) timeout_q <= 1'b0;
            if (state_q == S_WB) retire_cnt <= retire_cnt + 1'b1;
        end
    end

    assign state   = state_q;
    assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign illegal = illegal_q;
    assign timeout = timeout_q;

endmodule
